// File: rtl/wave_playback_ctrl.sv
// Per-channel DAC playback controller: streams a triggered, masked, optionally
// repeated burst from the waveform FIFO to the converter, with serial config.
module wave_playback_ctrl #(
    parameter int DATA_W   = 256,
    parameter int SAMPLE_W = 16,
    parameter int CNT_W    = 32,
    parameter int REP_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic              cfg_select,
    input  logic [4:0]        cfg_shift,
    input  logic              cfg_sdata,
    input  logic              trigger_in,
    input  logic              stop_in,
    output logic              mux_sel,
    output logic              busy,
    output logic              done,
    output logic              underflow,
    output logic              trig_miss
);

    localparam int LANES = DATA_W / SAMPLE_W;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [LANES-1:0]  r_head_mask;
    logic [LANES-1:0]  r_tail_mask;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [REP_W-1:0]  r_rep_cnt;
    logic [2:0]        r_mode;

    logic [CNT_W-1:0]  r_beat_ctr;
    logic [CNT_W-1:0]  w_beat_ctr_nxt;
    logic [REP_W-1:0]  r_rep_ctr;
    logic [REP_W-1:0]  w_rep_ctr_nxt;
    logic              r_first;
    logic              w_first_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_underflow;
    logic              r_trig_miss;
    logic [DATA_W-1:0] r_tdata;
    logic [DATA_W-1:0] w_tdata_nxt;
    logic [LANES-1:0]  w_lane_en;

    logic w_run;
    logic w_cfg_en;
    logic w_continuous;
    logic w_clear_flags;
    logic w_unused;

    assign w_run         = (r_state == ST_RUN);
    assign w_cfg_en      = cfg_select && !w_run;
    assign w_continuous  = r_mode[1];
    assign w_clear_flags = r_mode[2];

    // The converter pulls a sample every cycle, so its ready is meaningless here.
    assign w_unused = m_axis_tready;

    // NOTE: config registers are plain flops, not a memory, so they take the reset like any state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head_mask <= '0;
            r_tail_mask <= '0;
            r_beat_cnt  <= '0;
            r_rep_cnt   <= '0;
            r_mode      <= '0;
        end else begin
            if (w_cfg_en && cfg_shift[0]) r_head_mask <= {r_head_mask[LANES-2:0], cfg_sdata};
            if (w_cfg_en && cfg_shift[1]) r_tail_mask <= {r_tail_mask[LANES-2:0], cfg_sdata};
            if (w_cfg_en && cfg_shift[2]) r_beat_cnt  <= {r_beat_cnt[CNT_W-2:0], cfg_sdata};
            if (w_cfg_en && cfg_shift[3]) r_rep_cnt   <= {r_rep_cnt[REP_W-2:0], cfg_sdata};
            if (w_cfg_en && cfg_shift[4]) begin
                r_mode <= {r_mode[1:0], cfg_sdata};
            end else if (w_clear_flags) begin
                r_mode[2] <= 1'b0;
            end
        end
    end

    // A flag event in the same cycle as a clear request wins, so no event is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_underflow <= 1'b0;
            r_trig_miss <= 1'b0;
        end else begin
            if (w_clear_flags) begin
                r_underflow <= 1'b0;
                r_trig_miss <= 1'b0;
            end
            if (w_run && !s_axis_tvalid) r_underflow <= 1'b1;
            if (w_run && trigger_in)     r_trig_miss <= 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_beat_ctr_nxt = r_beat_ctr;
        w_rep_ctr_nxt  = r_rep_ctr;
        w_first_nxt    = r_first;
        w_done_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (trigger_in && !stop_in) begin
                    w_state_nxt    = ST_RUN;
                    w_beat_ctr_nxt = r_beat_cnt;
                    w_rep_ctr_nxt  = r_rep_cnt;
                    w_first_nxt    = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop_in) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                    w_first_nxt = 1'b0;
                end else if (r_beat_ctr != '0) begin
                    w_beat_ctr_nxt = r_beat_ctr - CNT_W'(1);
                    w_first_nxt    = 1'b0;
                end else if ((r_rep_ctr != '0) || w_continuous) begin
                    w_beat_ctr_nxt = r_beat_cnt;
                    if (!w_continuous) w_rep_ctr_nxt = r_rep_ctr - REP_W'(1);
                    w_first_nxt    = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                    w_first_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // First beat of a repetition takes head_mask, last takes tail_mask, a lone beat takes both.
    always_comb begin
        w_lane_en = '1;
        if (r_first)            w_lane_en = w_lane_en & r_head_mask;
        if (r_beat_ctr == '0)   w_lane_en = w_lane_en & r_tail_mask;

        w_tdata_nxt = '0;
        if (w_run && !stop_in && s_axis_tvalid) begin
            for (int k = 0; k < LANES; k++) begin
                if (w_lane_en[k]) begin
                    w_tdata_nxt[k*SAMPLE_W +: SAMPLE_W] = s_axis_tdata[k*SAMPLE_W +: SAMPLE_W];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_beat_ctr <= '0;
            r_rep_ctr  <= '0;
            r_first    <= 1'b0;
            r_done     <= 1'b0;
            r_tdata    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_ctr <= w_beat_ctr_nxt;
            r_rep_ctr  <= w_rep_ctr_nxt;
            r_first    <= w_first_nxt;
            r_done     <= w_done_nxt;
            r_tdata    <= w_tdata_nxt;
        end
    end

    assign s_axis_tready = w_run;
    assign busy          = w_run;
    assign m_axis_tvalid = 1'b1;
    assign m_axis_tdata  = r_tdata;
    assign done          = r_done;
    assign underflow     = r_underflow;
    assign trig_miss     = r_trig_miss;
    assign mux_sel       = r_mode[0];

endmodule

// File: tb/tb_wave_playback_ctrl.sv
// Scoreboard bench for wave_playback_ctrl: a negedge driver feeds the FIFO side,
// pushes the expected masked beat per pop and compares it one cycle later.
module tb_wave_playback_ctrl;

    localparam int DATA_W = 256;
    localparam int LANES  = 16;

    typedef struct packed {
        logic [LANES-1:0] mask;
        logic             valid;
        logic             stop;
    } desc_t;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              cfg_select;
    logic [4:0]        cfg_shift;
    logic              cfg_sdata;
    logic              trigger_in;
    logic              stop_in;
    logic              mux_sel;
    logic              busy;
    logic              done;
    logic              underflow;
    logic              trig_miss;

    wave_playback_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .cfg_select    (cfg_select),
        .cfg_shift     (cfg_shift),
        .cfg_sdata     (cfg_sdata),
        .trigger_in    (trigger_in),
        .stop_in       (stop_in),
        .mux_sel       (mux_sel),
        .busy          (busy),
        .done          (done),
        .underflow     (underflow),
        .trig_miss     (trig_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pop_cnt  = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int p0, b0, d0;
    bit fill_ones = 1'b0;

    desc_t             desc_q[$];
    logic [DATA_W-1:0] exp_q[$];
    bit                pend = 1'b0;
    desc_t             drv_d;
    logic [DATA_W-1:0] drv_e;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [DATA_W-1:0] expand(input logic [LANES-1:0] m);
        logic [DATA_W-1:0] e;
        for (int k = 0; k < LANES; k++) e[k*16 +: 16] = {16{m[k]}};
        return e;
    endfunction

    // FIFO source, flag/pop counters and scoreboard, all on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            pend = 1'b0;
            desc_q.delete();
            exp_q.delete();
        end else begin
            if (pend) begin
                check("beat", m_axis_tdata, exp_q.pop_front());
                pend = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            for (int w = 0; w < DATA_W / 32; w++) s_axis_tdata[w*32 +: 32] = fill_ones ? 32'hFFFF_FFFF : $urandom;
            s_axis_tvalid = 1'b1;
            if (s_axis_tready) begin
                pop_cnt++;
                check("desc_avail", DATA_W'(desc_q.size() != 0), DATA_W'(1));
                if (desc_q.size() != 0) begin
                    drv_d         = desc_q.pop_front();
                    s_axis_tvalid = drv_d.valid;
                    stop_in       = drv_d.stop;
                    drv_e = (drv_d.valid && !drv_d.stop) ? (s_axis_tdata & expand(drv_d.mask)) : '0;
                    exp_q.push_back(drv_e);
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic load(input int idx, input int width, input logic [31:0] v);
        for (int i = width - 1; i >= 0; i--) begin
            @(negedge clk);
            cfg_select = 1'b1;
            cfg_shift  = 5'(1 << idx);
            cfg_sdata  = v[i];
        end
        @(negedge clk);
        cfg_select = 1'b0;
        cfg_shift  = '0;
        cfg_sdata  = 1'b0;
    endtask

    task automatic push_run(input int nb, input int nr, input logic [LANES-1:0] hm,
                            input logic [LANES-1:0] tm, input int uf);
        int idx;
        desc_t d;
        idx = 0;
        for (int r = 0; r <= nr; r++) begin
            for (int b = 0; b <= nb; b++) begin
                d.mask = '1;
                if (b == 0)  d.mask = d.mask & hm;
                if (b == nb) d.mask = d.mask & tm;
                d.valid = (idx != uf);
                d.stop  = 1'b0;
                desc_q.push_back(d);
                idx++;
            end
        end
    endtask

    task automatic start_run();
        p0 = pop_cnt;
        b0 = busy_cnt;
        d0 = done_cnt;
        @(negedge clk);
        trigger_in = 1'b1;
        @(negedge clk);
        trigger_in = 1'b0;
    endtask

    task automatic wait_for_done(input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", DATA_W'(done), DATA_W'(1));
        check("ready_at_done", DATA_W'(s_axis_tready), DATA_W'(0));
    endtask

    task automatic finish_run(input string tag, input int pops, input int dones);
        wait_for_done(400);
        @(negedge clk);
        check({tag, "_pops"}, DATA_W'(pop_cnt - p0), DATA_W'(pops));
        check({tag, "_busy"}, DATA_W'(busy_cnt - b0), DATA_W'(pops));
        check({tag, "_done"}, DATA_W'(done_cnt - d0), DATA_W'(dones));
        check({tag, "_left"}, DATA_W'(desc_q.size()), DATA_W'(0));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tdata"}, m_axis_tdata, '0);
        check({tag, "_tvalid"}, DATA_W'(m_axis_tvalid), DATA_W'(1));
        check({tag, "_tready"}, DATA_W'(s_axis_tready), DATA_W'(0));
        check({tag, "_busy"}, DATA_W'(busy), DATA_W'(0));
        check({tag, "_done"}, DATA_W'(done), DATA_W'(0));
        check({tag, "_uf"}, DATA_W'(underflow), DATA_W'(0));
        check({tag, "_miss"}, DATA_W'(trig_miss), DATA_W'(0));
        check({tag, "_mux"}, DATA_W'(mux_sel), DATA_W'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        cfg_select    = 1'b0;
        cfg_shift     = '0;
        cfg_sdata     = 1'b0;
        trigger_in    = 1'b0;
        stop_in       = 1'b0;
        #12;
        check_reset_vals("rst0");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // mode[0] drives the write-mux select
        load(4, 3, 32'h1);
        check("mux_on", DATA_W'(mux_sel), DATA_W'(1));
        load(4, 3, 32'h0);
        @(negedge clk);
        check("mux_off", DATA_W'(mux_sel), DATA_W'(0));

        // single 4-beat burst, head drops lane0, tail drops lane15
        fill_ones = 1'b1;
        load(0, 16, 32'hFFFE);
        load(1, 16, 32'h7FFF);
        load(2, 32, 32'd3);
        load(3, 16, 32'd0);
        push_run(3, 0, 16'hFFFE, 16'h7FFF, -1);
        start_run();
        finish_run("t1", 4, 1);
        fill_ones = 1'b0;

        // three one-beat repetitions, head & tail ANDed
        load(0, 16, 32'h00FF);
        load(1, 16, 32'h0FF0);
        load(2, 32, 32'd0);
        load(3, 16, 32'd2);
        push_run(0, 2, 16'h00FF, 16'h0FF0, -1);
        start_run();
        finish_run("t2", 3, 1);

        // continuous two-beat loop stopped on the 7th pop
        load(4, 3, 32'h2);
        load(0, 16, 32'h0F0F);
        load(1, 16, 32'hFFFF);
        load(2, 32, 32'd1);
        for (int i = 0; i < 7; i++) begin
            desc_t d;
            d.mask  = (i % 2 == 0) ? 16'h0F0F : 16'hFFFF;
            d.valid = 1'b1;
            d.stop  = (i == 6);
            desc_q.push_back(d);
        end
        start_run();
        finish_run("t3", 7, 1);
        stop_in = 1'b0;
        load(4, 3, 32'h0);

        // underflow on the 2nd beat, then cleared by clear_flags
        load(0, 16, 32'hFFFF);
        load(1, 16, 32'hFFFF);
        load(2, 32, 32'd3);
        load(3, 16, 32'd0);
        check("t4_uf_pre", DATA_W'(underflow), DATA_W'(0));
        push_run(3, 0, 16'hFFFF, 16'hFFFF, 1);
        start_run();
        finish_run("t4", 4, 1);
        check("t4_uf_set", DATA_W'(underflow), DATA_W'(1));
        repeat (3) @(negedge clk);
        check("t4_uf_sticky", DATA_W'(underflow), DATA_W'(1));
        load(4, 3, 32'h4);
        @(negedge clk);
        check("t4_uf_clr", DATA_W'(underflow), DATA_W'(0));
        check("t4_mode_selfclr", DATA_W'(mux_sel), DATA_W'(0));

        // trigger while running and a config shift while busy are both ignored
        load(2, 32, 32'd7);
        check("t5_miss_pre", DATA_W'(trig_miss), DATA_W'(0));
        push_run(7, 0, 16'hFFFF, 16'hFFFF, -1);
        start_run();
        @(negedge clk);
        trigger_in = 1'b1;
        @(negedge clk);
        trigger_in = 1'b0;
        cfg_select = 1'b1;
        cfg_shift  = 5'b00100;
        cfg_sdata  = 1'b1;
        repeat (3) @(negedge clk);
        cfg_select = 1'b0;
        cfg_shift  = '0;
        cfg_sdata  = 1'b0;
        finish_run("t5", 8, 1);
        check("t5_miss", DATA_W'(trig_miss), DATA_W'(1));
        push_run(7, 0, 16'hFFFF, 16'hFFFF, -1);
        start_run();
        finish_run("t5b", 8, 1);
        load(4, 3, 32'h4);
        @(negedge clk);
        check("t5_miss_clr", DATA_W'(trig_miss), DATA_W'(0));

        // back-to-back playback: re-trigger in the done cycle
        load(0, 16, 32'h00FF);
        load(1, 16, 32'hFF00);
        load(2, 32, 32'd2);
        load(3, 16, 32'd1);
        push_run(2, 1, 16'h00FF, 16'hFF00, -1);
        push_run(2, 1, 16'h00FF, 16'hFF00, -1);
        start_run();
        wait_for_done(100);
        trigger_in = 1'b1;
        @(negedge clk);
        trigger_in = 1'b0;
        check("t6_b2b_busy", DATA_W'(busy), DATA_W'(1));
        finish_run("t6", 12, 2);
        check("t6_miss", DATA_W'(trig_miss), DATA_W'(0));

        // trigger together with stop in IDLE does nothing
        p0 = pop_cnt;
        d0 = done_cnt;
        @(negedge clk);
        trigger_in = 1'b1;
        stop_in    = 1'b1;
        @(negedge clk);
        trigger_in = 1'b0;
        stop_in    = 1'b0;
        repeat (4) @(negedge clk);
        check("t7_busy", DATA_W'(busy), DATA_W'(0));
        check("t7_pops", DATA_W'(pop_cnt - p0), DATA_W'(0));
        check("t7_done", DATA_W'(done_cnt - d0), DATA_W'(0));

        // asynchronous reset mid-run, then playback with cleared config
        load(4, 3, 32'h1);
        push_run(2, 1, 16'h00FF, 16'hFF00, -1);
        start_run();
        repeat (2) @(negedge clk);
        trigger_in = 1'b1;
        @(negedge clk);
        trigger_in = 1'b0;
        check("t8_miss_pre", DATA_W'(trig_miss), DATA_W'(1));
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("t8_rst");
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        push_run(0, 0, 16'h0000, 16'h0000, -1);
        start_run();
        finish_run("t8", 1, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
